// File: rtl/latch_bank_if.sv
// Client/latch-bank signal bundle for latch_bank_arbiter: two write requesters
// plus the shared latch data bus and one-hot latch enables.
interface latch_bank_if #(
   parameter int DW = 8,
   parameter int AW = 2
);
   logic                 req0;
   logic                 req1;
   logic [AW-1:0]        addr0;
   logic [AW-1:0]        addr1;
   logic [DW-1:0]        data0;
   logic [DW-1:0]        data1;
   logic [1:0]           gnt;
   logic [1:0]           ack;
   logic                 busy;
   logic [DW-1:0]        lat_d;
   logic [(1<<AW)-1:0]   lat_c;

   modport master (
      output req0, req1, addr0, addr1, data0, data1,
      input  gnt, ack, busy, lat_d, lat_c
   );

   modport slave (
      input  req0, req1, addr0, addr1, data0, data1,
      output gnt, ack, busy, lat_d, lat_c
   );
endinterface

// File: rtl/latch_bank_arbiter.sv
// Two-client write arbiter driving a latch bank with setup/open/hold phasing.
// Define LATCH_ARB_FIXED_PRIO_EN for fixed priority (req0 wins); default is round-robin.
module latch_bank_arbiter #(
   parameter int DW = 8,
   parameter int AW = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   latch_bank_if.slave  bus
);
   localparam int NE = 1 << AW;

   typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

   state_t          state_reg, state_next;
   logic [1:0]      gnt_reg, gnt_next;
   logic [1:0]      ack_reg, ack_next;
   logic            busy_reg, busy_next;
   logic [DW-1:0]   lat_d_reg, lat_d_next;
   logic [NE-1:0]   lat_c_reg, lat_c_next;
   logic [AW-1:0]   addr_reg, addr_next;
   logic            last_reg, last_next;
   logic            win;
   logic [NE-1:0]   dec;

   for (genvar gi = 0; gi < NE; gi++) begin : g_dec
      assign dec[gi] = (addr_reg == AW'(gi));
   end

   // win = index of the requester to grant; only meaningful when one is pending
   always_comb begin
`ifdef LATCH_ARB_FIXED_PRIO_EN
      win = ~bus.req0;
`else
      if (bus.req0 && bus.req1)
         win = ~last_reg;
      else
         win = ~bus.req0;
`endif
   end

   always_comb begin
      state_next = state_reg;
      gnt_next   = gnt_reg;
      ack_next   = 2'b00;
      lat_d_next = lat_d_reg;
      lat_c_next = '0;
      addr_next  = addr_reg;
      last_next  = last_reg;
      case (state_reg)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               state_next = SETUP;
               gnt_next   = win ? 2'b10 : 2'b01;
               lat_d_next = win ? bus.data1 : bus.data0;
               addr_next  = win ? bus.addr1 : bus.addr0;
               last_next  = win;
            end
         end
         SETUP: begin
            state_next = OPEN;
            lat_c_next = dec;
         end
         OPEN: begin
            state_next = HOLD;
            ack_next   = gnt_reg;
         end
         HOLD: begin
            state_next = IDLE;
            gnt_next   = 2'b00;
         end
         default: state_next = IDLE;
      endcase
      busy_next = (state_next != IDLE);
   end

   // Async reset drops lat_c at once so an open latch closes without a clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         gnt_reg   <= 2'b00;
         ack_reg   <= 2'b00;
         busy_reg  <= 1'b0;
         lat_d_reg <= '0;
         lat_c_reg <= '0;
         addr_reg  <= '0;
         last_reg  <= 1'b1;
      end else begin
         state_reg <= state_next;
         gnt_reg   <= gnt_next;
         ack_reg   <= ack_next;
         busy_reg  <= busy_next;
         lat_d_reg <= lat_d_next;
         lat_c_reg <= lat_c_next;
         addr_reg  <= addr_next;
         last_reg  <= last_next;
      end
   end

   assign bus.gnt   = gnt_reg;
   assign bus.ack   = ack_reg;
   assign bus.busy  = busy_reg;
   assign bus.lat_d = lat_d_reg;
   assign bus.lat_c = lat_c_reg;
endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Bench for latch_bank_arbiter: directed spec scenarios plus randomized clients,
// checked every cycle against a write-timeline reference model.
module tb_latch_bank_arbiter;
   localparam int DW = 8;
   localparam int AW = 2;
`ifdef LATCH_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic cmp_en = 1'b0;
   int   errors = 0;
   int   checks = 0;

   latch_bank_if #(.DW(DW), .AW(AW)) bus ();

   latch_bank_arbiter #(.DW(DW), .AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a write is a 3-cycle timeline counted from its grant
   int            m_cnt;
   logic          m_w, m_last, m_pick;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;

   always_comb begin
      if (bus.req0 && bus.req1)
         m_pick = FIXED ? 1'b0 : !m_last;
      else
         m_pick = !bus.req0;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt <= 0; m_w <= 1'b0; m_last <= 1'b1; m_addr <= '0; m_data <= '0;
      end else if (m_cnt == 0) begin
         if (bus.req0 || bus.req1) begin
            m_cnt  <= 1;
            m_w    <= m_pick;
            m_last <= m_pick;
            m_addr <= m_pick ? bus.addr1 : bus.addr0;
            m_data <= m_pick ? bus.data1 : bus.data0;
         end
      end else begin
         m_cnt <= (m_cnt == 3) ? 0 : m_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("gnt",   32'(bus.gnt),   (m_cnt != 0) ? 32'(2'b01 << m_w) : 32'd0);
         chk("lat_c", 32'(bus.lat_c), (m_cnt == 2) ? 32'(4'b0001 << m_addr) : 32'd0);
         chk("ack",   32'(bus.ack),   (m_cnt == 3) ? 32'(2'b01 << m_w) : 32'd0);
         chk("busy",  32'(bus.busy),  32'(m_cnt != 0));
         chk("lat_d", 32'(bus.lat_d), 32'(m_data));
         if (bus.ack != 2'b00)
            $display("write done: ack=%b lat_d=%h", bus.ack, bus.lat_d);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   int bcnt;

   initial begin
      bus.req0 = 0; bus.req1 = 0;
      bus.addr0 = '0; bus.addr1 = '0; bus.data0 = '0; bus.data1 = '0;
      #2 rst_n = 1'b0;
      #1 cmp_en = 1'b1;
      tick; tick;
      chk("rst_gnt",   32'(bus.gnt),   0);
      chk("rst_ack",   32'(bus.ack),   0);
      chk("rst_busy",  32'(bus.busy),  0);
      chk("rst_lat_c", 32'(bus.lat_c), 0);
      chk("rst_lat_d", 32'(bus.lat_d), 0);
      rst_n = 1'b1;

      // single write from requester 0
      bus.req0 = 1; bus.addr0 = 2'd2; bus.data0 = 8'hA5;
      tick;
      chk("w0_lat_d", 32'(bus.lat_d), 32'hA5);
      chk("w0_gnt",   32'(bus.gnt),   32'b01);
      chk("w0_setup_c", 32'(bus.lat_c), 0);
      tick;
      chk("w0_open_c", 32'(bus.lat_c), 32'b0100);
      tick;
      chk("w0_hold_c", 32'(bus.lat_c), 0);
      chk("w0_ack",    32'(bus.ack),   32'b01);
      bus.req0 = 0;
      tick;
      chk("w0_idle_busy", 32'(bus.busy), 0);

      // data change during OPEN is ignored
      bus.req0 = 1; bus.addr0 = 2'd1; bus.data0 = 8'h3C;
      tick;
      chk("dh_setup_d", 32'(bus.lat_d), 32'h3C);
      tick;
      bus.data0 = 8'hFF;
      tick;
      chk("dh_hold_d", 32'(bus.lat_d), 32'h3C);
      bus.req0 = 0;
      tick;
      chk("dh_idle_d", 32'(bus.lat_d), 32'h3C);

      // requester 1 alone
      bus.req1 = 1; bus.addr1 = 2'd1; bus.data1 = 8'h5A;
      bcnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (bus.busy) bcnt++;
         if (i == 0) chk("r1_gnt", 32'(bus.gnt), 32'b10);
         if (i == 1) chk("r1_lat_c", 32'(bus.lat_c), 32'b0010);
         if (i == 2) begin
            chk("r1_ack", 32'(bus.ack), 32'b10);
            bus.req1 = 0;
         end
      end
      chk("r1_busy_cycles", bcnt, 3);

      // both held continuously
      bus.req0 = 1; bus.addr0 = 2'd0; bus.data0 = 8'h11;
      bus.req1 = 1; bus.addr1 = 2'd3; bus.data1 = 8'h22;
      for (int k = 0; k < 4; k++) begin
         logic ew;
         ew = FIXED ? 1'b0 : k[0];
         tick;
         chk("rr_gnt",   32'(bus.gnt),   ew ? 32'b10 : 32'b01);
         chk("rr_lat_d", 32'(bus.lat_d), ew ? 32'h22 : 32'h11);
         tick;
         chk("rr_lat_c", 32'(bus.lat_c), ew ? 32'b1000 : 32'b0001);
         tick;
         chk("rr_ack",   32'(bus.ack),   ew ? 32'b10 : 32'b01);
         tick;
         chk("rr_idle",  32'(bus.busy),  0);
      end
      bus.req0 = 0; bus.req1 = 0;
      tick; tick;

      // async reset in the middle of OPEN
      bus.req0 = 1; bus.addr0 = 2'd2; bus.data0 = 8'h77;
      tick; tick;
      chk("ar_open_c", 32'(bus.lat_c), 32'b0100);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_lat_c", 32'(bus.lat_c), 0);
      chk("ar_busy",  32'(bus.busy),  0);
      chk("ar_ack",   32'(bus.ack),   0);
      chk("ar_gnt",   32'(bus.gnt),   0);
      bus.req1 = 1; bus.addr1 = 2'd3; bus.data1 = 8'h99;
      tick;
      rst_n = 1'b1;
      tick;
      chk("ar_first_gnt", 32'(bus.gnt), 32'b01);

      // randomized protocol-abiding clients
      repeat (3000) begin
         tick;
         if (bus.req0) begin
            if (bus.ack[0]) begin
               bus.req0 = ($urandom_range(0, 3) == 0);
               bus.addr0 = AW'($urandom); bus.data0 = DW'($urandom);
            end
         end else if ($urandom_range(0, 2) == 0) begin
            bus.req0 = 1; bus.addr0 = AW'($urandom); bus.data0 = DW'($urandom);
         end
         if (bus.req1) begin
            if (bus.ack[1]) begin
               bus.req1 = ($urandom_range(0, 3) == 0);
               bus.addr1 = AW'($urandom); bus.data1 = DW'($urandom);
            end
         end else if ($urandom_range(0, 2) == 0) begin
            bus.req1 = 1; bus.addr1 = AW'($urandom); bus.data1 = DW'($urandom);
         end
      end
      bus.req0 = 0; bus.req1 = 0;
      repeat (6) tick;
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
